// File: rtl/load_store_unit_if.sv
// Pipeline and data-memory signals of the load/store unit.
// LSU_MISALIGN_TRAP_EN adds the misaligned indication.
interface load_store_unit_if;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        mem_write;
  logic        mem_read;
  logic [1:0]  size;
  logic        load_unsigned;
  logic [31:0] read_data;
  logic        stall;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write_en;
  logic        mem_read_en;
  logic [31:0] mem_read_data;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  modport slave (
    input  address, write_data, mem_write, mem_read, size, load_unsigned, mem_read_data,
    output read_data, stall, mem_address, mem_write_data, mem_write_en, mem_read_en
`ifdef LSU_MISALIGN_TRAP_EN
    , output misaligned
`endif
  );

  modport master (
    output address, write_data, mem_write, mem_read, size, load_unsigned, mem_read_data,
    input  read_data, stall, mem_address, mem_write_data, mem_write_en, mem_read_en
`ifdef LSU_MISALIGN_TRAP_EN
    , input misaligned
`endif
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: lane-aligned loads, sub-word stores via read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to block misaligned halfword/word accesses.
module load_store_unit (
  input logic             clk,
  input logic             rst_n,
  load_store_unit_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StMerge} state_e;

  state_e      state_q;
  logic [31:0] merge_q;

  logic        is_byte, is_half, is_word;
  logic [4:0]  lane_shift;
  logic [31:0] lane_mask;
  logic [31:0] lane_val;
  logic        sign_bit;
  logic [31:0] load_val;
  logic [31:0] merged;
  logic        misalign;
  logic        sub_store;

  always_comb begin
    is_byte    = (bus.size == 2'b10);
    is_half    = (bus.size == 2'b01);
    is_word    = !is_byte && !is_half;
    lane_shift = is_byte ? {bus.address[1:0], 3'b000} : {bus.address[1], 4'b0000};
    lane_mask  = is_byte ? 32'h0000_00ff : 32'h0000_ffff;
    lane_val   = (bus.mem_read_data >> lane_shift) & lane_mask;
    sign_bit   = is_byte ? lane_val[7] : lane_val[15];
    if (is_word) begin
      load_val = bus.mem_read_data;
    end else if (sign_bit && !bus.load_unsigned) begin
      load_val = lane_val | ~lane_mask;
    end else begin
      load_val = lane_val;
    end
    merged = (merge_q & ~(lane_mask << lane_shift)) |
             ((bus.write_data & lane_mask) << lane_shift);
`ifdef LSU_MISALIGN_TRAP_EN
    misalign = (bus.mem_read || bus.mem_write) &&
               ((is_half && bus.address[0]) || (is_word && (bus.address[1:0] != 2'b00)));
`else
    misalign = 1'b0;
`endif
    sub_store = (state_q == StIdle) && bus.mem_write && !is_word && !misalign;
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign bus.misaligned = misalign;
`endif

  assign bus.mem_address = {bus.address[31:2], 2'b00};

  always_comb begin
    bus.stall          = 1'b0;
    bus.mem_write_en   = 1'b0;
    bus.mem_read_en    = 1'b0;
    bus.read_data      = 32'h0;
    bus.mem_write_data = bus.write_data;
    if (rst_n) begin
      case (state_q)
        StIdle: begin
          if (!misalign) begin
            // Store wins over a simultaneous load; the load result stays 0.
            if (bus.mem_write) begin
              if (is_word) begin
                bus.mem_write_en = 1'b1;
              end else begin
                bus.stall       = 1'b1;
                bus.mem_read_en = 1'b1;
              end
            end else if (bus.mem_read) begin
              bus.mem_read_en = 1'b1;
              bus.read_data   = load_val;
            end
          end
        end
        StMerge: begin
          bus.mem_write_en   = 1'b1;
          bus.mem_write_data = merged;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      merge_q <= 32'h0;
    end else begin
      case (state_q)
        StIdle: begin
          if (sub_store) begin
            merge_q <= bus.mem_read_data;
            state_q <= StMerge;
          end
        end
        StMerge: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a byte-addressed reference memory.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  // Data memory seen by the DUT (word array) and the reference (byte array).
  logic [31:0] tb_mem [64];
  logic [7:0]  ref_bytes [256];

  assign bus.mem_read_data = tb_mem[bus.mem_address[7:2]];
  always @(posedge clk) if (bus.mem_write_en) tb_mem[bus.mem_address[7:2]] <= bus.mem_write_data;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] last_rdata, last_wdata;
  int stall_cycles, write_pulses;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic poke_word(input logic [31:0] a, input logic [31:0] w);
    logic [7:0] b;
    b = a[7:0] & 8'hfc;
    tb_mem[a[7:2]] = w;
    for (int i = 0; i < 4; i++) ref_bytes[b + 8'(i)] = w[8*i +: 8];
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0] & 8'hfc;
    return {ref_bytes[b + 8'd3], ref_bytes[b + 8'd2], ref_bytes[b + 8'd1], ref_bytes[b]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz,
                                           input logic uns);
    logic [7:0]  v8;
    logic [15:0] v16;
    logic [7:0]  hb;
    hb = {a[7:1], 1'b0};
    case (sz)
      2'b10: begin
        v8 = ref_bytes[a[7:0]];
        return uns ? {24'h0, v8} : {{24{v8[7]}}, v8};
      end
      2'b01: begin
        v16 = {ref_bytes[hb + 8'd1], ref_bytes[hb]};
        return uns ? {16'h0, v16} : {{16{v16[15]}}, v16};
      end
      default: return ref_word(a);
    endcase
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    logic [7:0] hb, wb;
    hb = {a[7:1], 1'b0};
    wb = a[7:0] & 8'hfc;
    case (sz)
      2'b10: ref_bytes[a[7:0]] = d[7:0];
      2'b01: begin
        ref_bytes[hb]        = d[7:0];
        ref_bytes[hb + 8'd1] = d[15:8];
      end
      default: for (int i = 0; i < 4; i++) ref_bytes[wb + 8'(i)] = d[8*i +: 8];
    endcase
  endtask

  task automatic check_outs(input string tag, input logic [31:0] a, input logic st,
                            input logic we, input logic re, input logic [31:0] rdata,
                            input logic [31:0] wdata, input logic mis);
    check_eq({tag, "_stall"}, 32'(bus.stall), 32'(st));
    check_eq({tag, "_we"}, 32'(bus.mem_write_en), 32'(we));
    check_eq({tag, "_re"}, 32'(bus.mem_read_en), 32'(re));
    check_eq({tag, "_rdata"}, bus.read_data, rdata);
    check_eq({tag, "_maddr"}, bus.mem_address, {a[31:2], 2'b00});
    if (we) check_eq({tag, "_wdata"}, bus.mem_write_data, wdata);
`ifdef LSU_MISALIGN_TRAP_EN
    check_eq({tag, "_mis"}, 32'(bus.misaligned), 32'(mis));
`else
    if (mis) check_eq({tag, "_mis_unexpected"}, 32'(mis), 32'(0));
`endif
    last_rdata = bus.read_data;
    if (bus.stall) stall_cycles++;
    if (bus.mem_write_en) begin
      write_pulses++;
      last_wdata = bus.mem_write_data;
    end
  endtask

  // Entered and left just after a rising edge; no idle cycle is inserted.
  task automatic run_op(input string tag, input logic wr, input logic rd,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input logic uns);
    logic mis, sub;
    logic [31:0] exp_r;
    bus.mem_write     = wr;
    bus.mem_read      = rd;
    bus.address       = a;
    bus.write_data    = d;
    bus.size          = sz;
    bus.load_unsigned = uns;
    mis = TrapEn && (wr || rd) &&
          ((sz == 2'b01 && a[0]) || ((sz == 2'b00 || sz == 2'b11) && a[1:0] != 2'b00));
    sub = wr && (sz == 2'b01 || sz == 2'b10) && !mis;
    exp_r = (rd && !wr && !mis) ? ref_load(a, sz, uns) : 32'h0;
    @(negedge clk);
    check_outs({tag, "_c1"}, a, sub, wr && !mis && !sub, !mis && (sub || (rd && !wr)),
               exp_r, d, mis);
    if (wr && !mis) ref_store(a, d, sz);
    @(posedge clk);
    #1;
    if (sub) begin
      @(negedge clk);
      check_outs({tag, "_c2"}, a, 1'b0, 1'b1, 1'b0, 32'h0, ref_word(a), 1'b0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int c0;
    logic [31:0] a, d;
    int kind;

    stall_cycles = 0;
    write_pulses = 0;
    for (int i = 0; i < 64; i++) poke_word(32'(i * 4), $urandom);

    // Outputs held at zero under reset even with a load requested.
    rst_n = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_read = 1'b1;
    bus.address = 32'h0000_0010;
    bus.write_data = 32'h0;
    bus.size = 2'b00;
    bus.load_unsigned = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outs("reset", 32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_op("idle", 1'b0, 1'b0, 32'h0000_0044, 32'h1234_5678, 2'b00, 1'b0);

    // Word store then word load.
    stall_cycles = 0;
    write_pulses = 0;
    run_op("wst", 1'b1, 1'b0, 32'h0000_0010, 32'hdead_beef, 2'b00, 1'b0);
    run_op("wld", 1'b0, 1'b1, 32'h0000_0010, 32'h0, 2'b00, 1'b0);
    check_eq("wld_value", last_rdata, 32'hdead_beef);
    check_eq("wst_stalls", 32'(stall_cycles), 32'd0);
    check_eq("wst_pulses", 32'(write_pulses), 32'd1);

    // Byte store merge.
    poke_word(32'h20, 32'h1122_3344);
    stall_cycles = 0;
    run_op("bst", 1'b1, 1'b0, 32'h0000_0021, 32'h0000_00ab, 2'b10, 1'b0);
    check_eq("bst_wdata", last_wdata, 32'h1122_ab44);
    check_eq("bst_stalls", 32'(stall_cycles), 32'd1);

    // Sub-word loads with sign and zero extension.
    poke_word(32'h30, 32'h8000_ff7f);
    run_op("lb30", 1'b0, 1'b1, 32'h30, 32'h0, 2'b10, 1'b0);
    check_eq("lb30_value", last_rdata, 32'h0000_007f);
    run_op("lb31", 1'b0, 1'b1, 32'h31, 32'h0, 2'b10, 1'b0);
    check_eq("lb31_value", last_rdata, 32'hffff_ffff);
    run_op("lbu31", 1'b0, 1'b1, 32'h31, 32'h0, 2'b10, 1'b1);
    check_eq("lbu31_value", last_rdata, 32'h0000_00ff);
    run_op("lh32", 1'b0, 1'b1, 32'h32, 32'h0, 2'b01, 1'b0);
    check_eq("lh32_value", last_rdata, 32'hffff_8000);

    // Back-to-back sub-word stores.
    poke_word(32'h20, 32'h1122_3344);
    c0 = cyc;
    run_op("hst", 1'b1, 1'b0, 32'h22, 32'h0000_beef, 2'b01, 1'b0);
    check_eq("hst_wdata", last_wdata, 32'hbeef_3344);
    run_op("bst2", 1'b1, 1'b0, 32'h20, 32'h0000_0055, 2'b10, 1'b0);
    check_eq("bst2_wdata", last_wdata, 32'hbeef_3355);
    check_eq("b2b_cycles", 32'(cyc - c0), 32'd4);

    // Reset during MERGE aborts the write.
    poke_word(32'h24, 32'h5566_7788);
    bus.mem_write = 1'b1;
    bus.mem_read = 1'b0;
    bus.address = 32'h25;
    bus.write_data = 32'h0000_0099;
    bus.size = 2'b10;
    bus.load_unsigned = 1'b0;
    @(negedge clk);
    check_eq("rstm_c1_stall", 32'(bus.stall), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_read = 1'b1;
    bus.size = 2'b00;
    @(negedge clk);
    check_outs("rstm_c2", 32'h25, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_op("rstm_ld", 1'b0, 1'b1, 32'h24, 32'h0, 2'b00, 1'b0);
    check_eq("rstm_mem", last_rdata, 32'h5566_7788);

    // Misaligned word store.
    poke_word(32'h10, 32'h0bad_f00d);
    run_op("mis_wst", 1'b1, 1'b0, 32'h13, 32'hcafe_f00d, 2'b00, 1'b0);
    run_op("mis_ld", 1'b0, 1'b1, 32'h10, 32'h0, 2'b00, 1'b0);
    check_eq("mis_mem", last_rdata, TrapEn ? 32'h0bad_f00d : 32'hcafe_f00d);

    // Simultaneous read and write: store wins.
    run_op("rw", 1'b1, 1'b1, 32'h48, 32'h7777_1111, 2'b00, 1'b0);

    // Randomized mix.
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 9);
      a = {($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'h0, 8'($urandom)};
      d = $urandom;
      if (kind == 0) run_op("r_idle", 1'b0, 1'b0, a, d, 2'($urandom), 1'($urandom));
      else if (kind <= 4) run_op("r_st", 1'b1, 1'b0, a, d, 2'($urandom), 1'($urandom));
      else if (kind <= 8) run_op("r_ld", 1'b0, 1'b1, a, d, 2'($urandom), 1'($urandom));
      else run_op("r_rw", 1'b1, 1'b1, a, d, 2'($urandom), 1'($urandom));
    end
    bus.mem_write = 1'b0;
    bus.mem_read = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 64; i++) check_eq("final_mem", tb_mem[i], ref_word(32'(i * 4)));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
